afifo_gray_ptr_ctrl: RTL and testbench

//  Single-clock-domain pointer/flag engine for one side of the async FIFO. Holds the local

---
 rtl/afifo_gray_ptr_ctrl_pkg.sv | 16 +
 rtl/afifo_gray_ptr_ctrl_if.sv | 30 +++
 rtl/afifo_gray_ptr_ctrl_cvtr.sv | 26 ++
 rtl/afifo_gray_ptr_ctrl.sv | 81 ++++++++
 tb/tb_afifo_gray_ptr_ctrl.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/afifo_gray_ptr_ctrl_pkg.sv
// Shared constants and helpers for the async FIFO pointer/flag engines.
// A FIFO pointer carries one extra bit beyond the RAM address so full and empty can be told apart.
package afifo_pkg;

    localparam int MODE_WR = 0;
    localparam int MODE_RD = 1;

    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/afifo_gray_ptr_ctrl_if.sv
// Local-side bundle of one pointer engine: request, synchronised remote pointer and all status.
interface afifo_gray_ptr_ctrl_if
    import afifo_pkg::*;
#(
    parameter int ADDR_W = 4
);
    localparam int PW = ptr_w(ADDR_W);

    logic          inc;
    logic [PW-1:0] rmt_ptr_gray;
    logic          accept;
    logic [ADDR_W-1:0] addr;
    logic [PW-1:0] ptr_bin;
    logic [PW-1:0] ptr_gray;
    logic          flag;
    logic          almost;
    logic [PW-1:0] level;
    logic          err;

    modport slave (
        input  inc, rmt_ptr_gray,
        output accept, addr, ptr_bin, ptr_gray, flag, almost, level, err
    );

    modport master (
        output inc, rmt_ptr_gray,
        input  accept, addr, ptr_bin, ptr_gray, flag, almost, level, err
    );

endinterface

// File: rtl/afifo_gray_ptr_ctrl_cvtr.sv
// Combinational Gray/binary converters used on the pointer paths.
module afifo_gtob_cvtr #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);
    // Each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin[i] = ^(gray >> i);
        end
    end

endmodule

module afifo_btog_cvtr #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);
    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/afifo_gray_ptr_ctrl.sv
// One-domain pointer/flag engine of an async FIFO: write side (full/overflow) or read side
// (empty/underflow), selected by MODE. Only ptr_gray is meant to cross into the other domain.
module afifo_gray_ptr_ctrl
    import afifo_pkg::*;
#(
    parameter int ADDR_W     = 4,
    parameter int MODE       = 0,
    parameter int LVL_THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    afifo_gray_ptr_ctrl_if.slave bus
);
    localparam int PW    = ptr_w(ADDR_W);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [31:0] ALMOST_HI = 32'(DEPTH - LVL_THRESH);
    localparam logic [31:0] ALMOST_LO = 32'(LVL_THRESH);
    // Full when local is exactly one lap ahead: remote Gray with its two top bits inverted.
    localparam logic [PW-1:0] FULL_MASK = PW'(3) << (PW - 2);
    localparam logic RST_FLAG = (MODE == MODE_RD);

    logic [PW-1:0] bin_p0, gray_p0, rbin_p0, level_p0;
    logic          flag_p0, almost_p0, accept_p0;

    logic [PW-1:0] bin_p1, gray_p1, level_p1;
    logic          flag_p1, almost_p1, err_p1;

    // ---- stage p0: next-state pointer, remote decode, next flags ----
    afifo_btog_cvtr #(.WIDTH(PW)) u_btog (
        .bin  (bin_p0),
        .gray (gray_p0)
    );

    afifo_gtob_cvtr #(.WIDTH(PW)) u_gtob (
        .gray (bus.rmt_ptr_gray),
        .bin  (rbin_p0)
    );

    always_comb begin
        accept_p0 = bus.inc & ~flag_p1 & ~rst;
        bin_p0    = accept_p0 ? bin_p1 + PW'(1) : bin_p1;
        if (MODE == MODE_WR) begin
            flag_p0   = (gray_p0 == (bus.rmt_ptr_gray ^ FULL_MASK));
            level_p0  = bin_p0 - rbin_p0;
            almost_p0 = (32'(level_p0) >= ALMOST_HI);
        end else begin
            flag_p0   = (gray_p0 == bus.rmt_ptr_gray);
            level_p0  = rbin_p0 - bin_p0;
            almost_p0 = (32'(level_p0) <= ALMOST_LO);
        end
    end

    // ---- stage p1: registered pointer and status ----
    always_ff @(posedge clk) begin
        if (rst) begin
            bin_p1    <= '0;
            gray_p1   <= '0;
            level_p1  <= '0;
            flag_p1   <= RST_FLAG;
            almost_p1 <= RST_FLAG;
            err_p1    <= 1'b0;
        end else begin
            bin_p1    <= bin_p0;
            gray_p1   <= gray_p0;
            level_p1  <= level_p0;
            flag_p1   <= flag_p0;
            almost_p1 <= almost_p0;
            err_p1    <= err_p1 | (bus.inc & flag_p1);
        end
    end

    assign bus.accept   = accept_p0;
    assign bus.addr     = bin_p1[ADDR_W-1:0];
    assign bus.ptr_bin  = bin_p1;
    assign bus.ptr_gray = gray_p1;
    assign bus.flag     = flag_p1;
    assign bus.almost   = almost_p1;
    assign bus.level    = level_p1;
    assign bus.err      = err_p1;

endmodule

// File: tb/tb_afifo_gray_ptr_ctrl.sv
// Directed bench for a write-side and a read-side engine (ADDR_W=2, LVL_THRESH=1) against an occupancy-count model.
module tb_afifo_gray_ptr_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    afifo_gray_ptr_ctrl_if #(.ADDR_W(2)) wif ();
    afifo_gray_ptr_ctrl_if #(.ADDR_W(2)) rif ();

    afifo_gray_ptr_ctrl #(.ADDR_W(2), .MODE(0), .LVL_THRESH(1)) u_wr (
        .clk (clk),
        .rst (rst),
        .bus (wif)
    );

    afifo_gray_ptr_ctrl #(.ADDR_W(2), .MODE(1), .LVL_THRESH(1)) u_rd (
        .clk (clk),
        .rst (rst),
        .bus (rif)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: pointer as an accepted-operation count mod 8, occupancy as plain count difference.
    int e_ptr[2]    = '{0, 0};
    int e_lvl[2]    = '{0, 0};
    int e_flag[2]   = '{0, 1};
    int e_almost[2] = '{0, 1};
    int e_err[2]    = '{0, 0};
    int m_acc       = 0;
    bit last_rst    = 1'b1;
    bit chk_en      = 1'b0;

    function automatic int g2b(input int g);
        for (int b = 0; b < 8; b++)
            if ((b ^ (b >> 1)) == g) return b;
        return -1;
    endfunction

    function automatic int gray_of(input int b);
        return b ^ (b >> 1);
    endfunction

    always @(posedge clk) begin
        last_rst = rst;
        for (int d = 0; d < 2; d++) begin
            int inc_d, rmt_d, r, lvl;
            inc_d = (d == 0) ? int'(wif.inc) : int'(rif.inc);
            rmt_d = (d == 0) ? int'(wif.rmt_ptr_gray) : int'(rif.rmt_ptr_gray);
            if (rst) begin
                e_ptr[d] = 0; e_lvl[d] = 0; e_err[d] = 0;
                e_flag[d] = d; e_almost[d] = d;
            end else begin
                if (inc_d != 0 && e_flag[d] == 0) begin
                    e_ptr[d] = (e_ptr[d] + 1) % 8;
                    if (d == 0) m_acc++;
                end
                if (inc_d != 0 && e_flag[d] != 0) e_err[d] = 1;
                r   = g2b(rmt_d);
                lvl = (d == 0) ? (e_ptr[d] - r + 8) % 8 : (r - e_ptr[d] + 8) % 8;
                e_lvl[d]    = lvl;
                e_flag[d]   = (d == 0) ? int'(lvl == 4) : int'(lvl == 0);
                e_almost[d] = (d == 0) ? int'(lvl >= 3) : int'(lvl <= 1);
            end
        end
    end

    logic [2:0] prev_wg = '0;

    // Compare process: every output of both engines, every cycle once reset has been applied.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_ptr_bin",  32'(wif.ptr_bin),  32'(e_ptr[0]));
            chk("wr_ptr_gray", 32'(wif.ptr_gray), 32'(gray_of(e_ptr[0])));
            chk("wr_addr",     32'(wif.addr),     32'(e_ptr[0] % 4));
            chk("wr_flag",     32'(wif.flag),     32'(e_flag[0]));
            chk("wr_almost",   32'(wif.almost),   32'(e_almost[0]));
            chk("wr_level",    32'(wif.level),    32'(e_lvl[0]));
            chk("wr_err",      32'(wif.err),      32'(e_err[0]));
            chk("wr_accept",   32'(wif.accept),   32'(wif.inc && e_flag[0] == 0 && !rst));
            chk("rd_ptr_bin",  32'(rif.ptr_bin),  32'(e_ptr[1]));
            chk("rd_ptr_gray", 32'(rif.ptr_gray), 32'(gray_of(e_ptr[1])));
            chk("rd_addr",     32'(rif.addr),     32'(e_ptr[1] % 4));
            chk("rd_flag",     32'(rif.flag),     32'(e_flag[1]));
            chk("rd_almost",   32'(rif.almost),   32'(e_almost[1]));
            chk("rd_level",    32'(rif.level),    32'(e_lvl[1]));
            chk("rd_err",      32'(rif.err),      32'(e_err[1]));
            chk("rd_accept",   32'(rif.accept),   32'(rif.inc && e_flag[1] == 0 && !rst));
            if (!last_rst && wif.ptr_gray != prev_wg)
                chk("wr_gray_step", 32'($countones(wif.ptr_gray ^ prev_wg)), 32'd1);
            prev_wg = wif.ptr_gray;
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int h1, h2, acc0, cnt;
        bit wrap_seen, seen_full;
        logic [2:0] pg;

        // 1: reset held two cycles with requests asserted
        rst = 1'b1;
        wif.inc = 1'b1; rif.inc = 1'b1;
        wif.rmt_ptr_gray = '0; rif.rmt_ptr_gray = '0;
        cyc();
        chk_en = 1'b1;
        chk("s1_rst_accept", 32'(wif.accept), 32'd0);
        cyc();
        chk("s1_wr_ptr",  32'(wif.ptr_bin),  32'd0);
        chk("s1_wr_gray", 32'(wif.ptr_gray), 32'd0);
        chk("s1_wr_err",  32'(wif.err),      32'd0);
        chk("s1_wr_flag", 32'(wif.flag),     32'd0);
        chk("s1_rd_flag", 32'(rif.flag),     32'd1);

        // 2: write side fills against a stationary remote pointer, then overflows
        rst = 1'b0; rif.inc = 1'b0;
        cyc(); chk("s2_gray1", 32'(wif.ptr_gray), 32'b001);
        cyc(); chk("s2_gray2", 32'(wif.ptr_gray), 32'b011);
               chk("s2_alm2",  32'(wif.almost),   32'd0);
        cyc(); chk("s2_gray3", 32'(wif.ptr_gray), 32'b010);
               chk("s2_alm3",  32'(wif.almost),   32'd1);
               chk("s2_full3", 32'(wif.flag),     32'd0);
        cyc(); chk("s2_gray4", 32'(wif.ptr_gray), 32'b110);
               chk("s2_full4", 32'(wif.flag),     32'd1);
               chk("s2_lvl4",  32'(wif.level),    32'd4);
               chk("s2_acc5",  32'(wif.accept),   32'd0);
        cyc(); chk("s2_hold",  32'(wif.ptr_gray), 32'b110);
               chk("s2_err",   32'(wif.err),      32'd1);
        wif.inc = 1'b0;
        cyc(); chk("s2_sticky", 32'(wif.err), 32'd1);

        // 4: read side drains three entries written by a remote at binary 3
        rif.rmt_ptr_gray = 3'b010;
        cyc(); chk("s4_lvl3", 32'(rif.level), 32'd3);
               chk("s4_ne",   32'(rif.flag),  32'd0);
        rif.inc = 1'b1;
        cyc(); chk("s4_lvl2", 32'(rif.level),  32'd2);
               chk("s4_alm2", 32'(rif.almost), 32'd0);
        cyc(); chk("s4_lvl1", 32'(rif.level),  32'd1);
               chk("s4_alm1", 32'(rif.almost), 32'd1);
        cyc(); chk("s4_lvl0", 32'(rif.level),  32'd0);
               chk("s4_empty", 32'(rif.flag),  32'd1);
               chk("s4_acc4", 32'(rif.accept), 32'd0);
        cyc(); chk("s4_err",  32'(rif.err),    32'd1);
        rif.inc = 1'b0;

        // 3: remote trails the write pointer by two cycles; 16 accepts wrap the pointer twice
        rst = 1'b1; wif.rmt_ptr_gray = '0;
        cyc();
        rst = 1'b0;
        h1 = 0; h2 = 0; wrap_seen = 1'b0; seen_full = 1'b0;
        acc0 = m_acc; cnt = 0;
        pg = wif.ptr_gray;
        while (m_acc - acc0 < 16 && cnt < 40) begin
            wif.rmt_ptr_gray = 3'(h2);
            wif.inc = 1'b1;
            cyc();
            cnt++;
            if (pg == 3'b100 && wif.ptr_gray == 3'b000) wrap_seen = 1'b1;
            if (wif.flag) seen_full = 1'b1;
            pg = wif.ptr_gray;
            h2 = h1;
            h1 = gray_of(e_ptr[0]);
        end
        chk("s3_accepts", 32'(m_acc - acc0), 32'd16);
        chk("s3_ptr_end", 32'(wif.ptr_bin),  32'd0);
        chk("s3_wrap",    32'(wrap_seen),    32'd1);
        chk("s3_no_full", 32'(seen_full),    32'd0);

        // 5: local push and remote pop land on the same edge at level 3
        rst = 1'b1; wif.inc = 1'b0; wif.rmt_ptr_gray = '0;
        cyc();
        rst = 1'b0; wif.inc = 1'b1;
        cyc(); cyc(); cyc();
        chk("s5_lvl3", 32'(wif.level), 32'd3);
        wif.rmt_ptr_gray = 3'b001;
        #1;
        chk("s5_accept", 32'(wif.accept), 32'd1);
        cyc();
        chk("s5_lvl", 32'(wif.level), 32'd3);
        chk("s5_full", 32'(wif.flag), 32'd0);

        // 6: reset mid-operation with requests asserted
        rst = 1'b1; rif.inc = 1'b1;
        #1;
        chk("s6_accept", 32'(wif.accept), 32'd0);
        cyc();
        chk("s6_ptr",   32'(wif.ptr_bin), 32'd0);
        chk("s6_lvl",   32'(wif.level),   32'd0);
        chk("s6_flag",  32'(wif.flag),    32'd0);
        chk("s6_err",   32'(wif.err),     32'd0);
        chk("s6_rflag", 32'(rif.flag),    32'd1);
        rst = 1'b0; wif.inc = 1'b0; rif.inc = 1'b0;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
